rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/hdlc_pkg.sv | 19 +
 rtl/rx_zero_remover.sv | 44 ++++
 rtl/rx_deframer.sv | 139 +++++++++++++
 tb/tb_rx_deframer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive deframer.
package hdlc_pkg;

    // Opening/closing flag: 0111_1110.
    localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
    // Abort: a 0 followed by seven 1s.
    localparam logic [7:0] ABORT_PATTERN = 8'h7F;
    // After this many consecutive data 1s, a following 0 was inserted by the transmitter.
    localparam int unsigned STUFF_LIMIT  = 5;
    // Shifts still to discard after the one on the flag-detect edge itself (8 flag bits in total).
    localparam logic [2:0] FLAG_DISCARD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLAG  = 2'd1,
        FRAME = 2'd2
    } frame_state_t;

endpackage

// File: rtl/rx_zero_remover.sv
// Drops the transmitter-inserted 0 that follows STUFF_LIMIT consecutive data 1s.
module rx_zero_remover
    import hdlc_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic data_i,
    input  logic valid_i,
    input  logic clear_i,
    output logic data_o,
    output logic valid_o
);

    logic [2:0] ones_q;
    logic [2:0] ones_d;
    logic       stuffed;

    // Flag a stuffed zero and advance the saturating run-of-ones count.
    always_comb begin
        stuffed = valid_i && !data_i && (ones_q == 3'(STUFF_LIMIT));
        data_o  = data_i;
        valid_o = valid_i && !stuffed;
        ones_d  = ones_q;
        if (clear_i) begin
            ones_d = '0;
        end else if (valid_i) begin
            if (!data_i) begin
                ones_d = '0;
            end else if (ones_q != 3'd7) begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    // Run-of-ones register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag/abort detection, frame tracking, zero removal and byte assembly.
module rx_deframer
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_EndOfFrame,
    output logic       Rx_FrameError
);

    logic [7:0]   window_q, window_d;
    frame_state_t state_q, state_d;
    logic [2:0]   discard_q, discard_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   data_q, data_d;
    logic         flag_q, abort_q, valid_q, newbyte_q, eof_q, ferr_q;
    logic         eof_d, ferr_d, newbyte_d;
    logic         flag_hit, abort_hit, data_valid, zr_clear, zr_bit, zr_valid;

    // Window shifts every cycle regardless of enable; bit 0 is the newest.
    assign window_d[0] = Rx;
    for (genvar gi = 1; gi < 8; gi++) begin : g_window
        assign window_d[gi] = window_q[gi-1];
    end

    // Pattern matches and qualification of the bit leaving the oldest window slot.
    always_comb begin
        flag_hit   = RxEN && (window_q == FLAG_PATTERN);
        abort_hit  = RxEN && (window_q == ABORT_PATTERN);
        data_valid = RxEN && !flag_hit && !abort_hit &&
                     (state_q != IDLE) && (discard_q == 3'd0);
        zr_clear   = !RxEN || flag_hit || abort_hit || (state_q == IDLE);
    end

    rx_zero_remover u_zero_remover (
        .Clk     (Clk),
        .Rst     (Rst),
        .data_i  (window_q[7]),
        .valid_i (data_valid),
        .clear_i (zr_clear),
        .data_o  (zr_bit),
        .valid_o (zr_valid)
    );

    // Frame state machine next state, flag-bit discard count and end-of-frame pulses.
    always_comb begin
        state_d   = state_q;
        discard_d = (discard_q == 3'd0) ? 3'd0 : discard_q - 3'd1;
        eof_d     = 1'b0;
        ferr_d    = 1'b0;
        if (!RxEN) begin
            state_d   = IDLE;
            discard_d = '0;
        end else if (abort_hit) begin
            state_d = IDLE;
        end else if (flag_hit) begin
            state_d   = FLAG;
            discard_d = FLAG_DISCARD;
            if (state_q == FRAME) begin
                eof_d  = 1'b1;
                ferr_d = (bitcnt_q != 3'd0);
            end
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FLAG:    if (discard_q == 3'd0) state_d = FRAME;
                FRAME:   state_d = FRAME;
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte assembly, LSB first; partial bytes vanish on flag, abort or disable.
    always_comb begin
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        newbyte_d = 1'b0;
        if (zr_clear) begin
            bitcnt_d = '0;
            shift_d  = '0;
        end else if (zr_valid) begin
            shift_d  = {zr_bit, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                data_d    = {zr_bit, shift_q[7:1]};
                newbyte_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            window_q  <= 8'hFF;
            state_q   <= IDLE;
            discard_q <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            abort_q   <= 1'b0;
            valid_q   <= 1'b0;
            newbyte_q <= 1'b0;
            eof_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            window_q  <= window_d;
            state_q   <= state_d;
            discard_q <= discard_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            flag_q    <= flag_hit;
            abort_q   <= abort_hit;
            valid_q   <= (state_d == FRAME);
            newbyte_q <= newbyte_d;
            eof_q     <= eof_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = valid_q;
    assign Rx_NewByte     = newbyte_q;
    assign Rx_Data        = data_q;
    assign Rx_EndOfFrame  = eof_q;
    assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: a frame-level reference model queues expected pulses,
// a negedge monitor compares them against the DUT.
module tb_rx_deframer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx = 1'b1;
    logic       RxEN = 1'b0;
    logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_EndOfFrame, Rx_FrameError;

    rx_deframer dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx             (Rx),
        .RxEN           (RxEN),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_Data        (Rx_Data),
        .Rx_EndOfFrame  (Rx_EndOfFrame),
        .Rx_FrameError  (Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    typedef enum int {EV_FLAG, EV_ABORT, EV_BYTE, EV_EOF} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         edge_n;
        logic [7:0] data;
        logic       err;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  started = 1'b0;

    // Reference model state, expressed in terms of the received line.
    logic [7:0] m_win = 8'hFF;     // last eight sampled bits, newest in bit 0
    bit         m_open = 1'b0;     // a flag has been seen and not cancelled
    bit         m_in_frame = 1'b0; // data bits of the current frame are flowing
    int         m_fl_sample = 0;   // edge on which the last bit of the latest flag was sampled
    int         m_ones = 0;
    int         m_cnt = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_data = 8'h00;
    int         tx_ones = 0;

    task automatic push_ev(input ev_kind_t k, input logic [7:0] d, input logic e);
        ev_t ev;
        ev.kind   = k;
        ev.edge_n = cyc;
        ev.data   = d;
        ev.err    = e;
        exp_q.push_back(ev);
    endtask

    // Apply the receive rules for one clock edge.
    task automatic model_edge(input bit r, input bit en, input bit b);
        bit fl_prev, ab_prev, outb;
        started = 1'b1;
        if (r) begin
            m_win = 8'hFF; m_open = 0; m_in_frame = 0;
            m_ones = 0; m_cnt = 0; m_cur = 8'h00; m_data = 8'h00;
            return;
        end
        fl_prev = (m_win == 8'h7E);
        ab_prev = (m_win == 8'h7F);
        outb    = m_win[7];
        m_win   = {m_win[6:0], b};
        if (!en) begin
            m_open = 0; m_in_frame = 0;
            return;
        end
        if (fl_prev) begin
            push_ev(EV_FLAG, 8'h00, 1'b0);
            if (m_in_frame) push_ev(EV_EOF, 8'h00, (m_cnt != 0));
            m_open = 1; m_in_frame = 0; m_fl_sample = cyc - 1;
            m_ones = 0; m_cnt = 0; m_cur = 8'h00;
        end else if (ab_prev) begin
            push_ev(EV_ABORT, 8'h00, 1'b0);
            m_open = 0; m_in_frame = 0;
        end else if (m_open && (cyc - 8 > m_fl_sample)) begin
            // bit leaving the window was sampled after the flag ended: it is data
            m_in_frame = 1;
            if (m_ones == 5 && !outb) begin
                m_ones = 0;
            end else begin
                m_ones = outb ? m_ones + 1 : 0;
                m_cur[m_cnt] = outb;
                m_cnt++;
                if (m_cnt == 8) begin
                    push_ev(EV_BYTE, m_cur, 1'b0);
                    m_data = m_cur;
                    m_cnt = 0;
                    m_cur = 8'h00;
                end
            end
        end
    endtask

    task automatic check_pulse(input ev_kind_t k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s at edge %0d: DUT pulsed, model expected nothing", k.name(), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.edge_n != cyc ||
            (k == EV_BYTE && Rx_Data !== e.data) ||
            (k == EV_EOF && Rx_FrameError !== e.err)) begin
            fails++;
            $display("FAIL pulse_%s at edge %0d: got data=%02h ferr=%b, required %s at edge %0d data=%02h ferr=%b",
                     k.name(), cyc, Rx_Data, Rx_FrameError, e.kind.name(), e.edge_n, e.data, e.err);
        end else begin
            $display("[TB] edge %0d %s ok data=%02h ferr=%b", cyc, k.name(), Rx_Data, Rx_FrameError);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (started) begin
                while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                    tests++; fails++;
                    $display("FAIL missed_%s: no pulse observed, required at edge %0d", exp_q[0].kind.name(), exp_q[0].edge_n);
                    void'(exp_q.pop_front());
                end
                if (Rx_FlagDetect === 1'b1)  check_pulse(EV_FLAG);
                if (Rx_EndOfFrame === 1'b1)  check_pulse(EV_EOF);
                if (Rx_AbortDetect === 1'b1) check_pulse(EV_ABORT);
                if (Rx_NewByte === 1'b1)     check_pulse(EV_BYTE);
                tests++;
                if ((Rx_FrameError && !Rx_EndOfFrame) !== 1'b0) begin
                    fails++;
                    $display("FAIL lone_frame_error at edge %0d: ferr=%b eof=%b, required ferr only with eof", cyc, Rx_FrameError, Rx_EndOfFrame);
                end
                tests++;
                if (Rx_ValidFrame !== m_in_frame) begin
                    fails++;
                    $display("FAIL valid_frame at edge %0d: got %b, required %b", cyc, Rx_ValidFrame, m_in_frame);
                end
                tests++;
                if (Rx_Data !== m_data) begin
                    fails++;
                    $display("FAIL rx_data_hold at edge %0d: got %02h, required %02h", cyc, Rx_Data, m_data);
                end
            end
        end
    end

    // Stimulus helpers.
    task automatic step(input bit r, input bit en, input bit b);
        @(negedge Clk);
        Rst = r; RxEN = en; Rx = b;
        @(posedge Clk);
        cyc++;
        model_edge(r, en, b);
    endtask

    task automatic send_bit(input bit b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tx_ones = 0;
    endtask

    task automatic send_abort();
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
    endtask

    task automatic send_data_bit(input bit b);
        send_bit(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    initial begin
        int nb, kind;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        // idle line out of reset
        send_idle(20);
        // flag then idle
        send_flag(); send_idle(20);
        // single byte A5
        send_flag(); send_byte(8'hA5); send_flag(); send_idle(12);
        // byte FF needs a stuffed zero
        send_flag(); send_byte(8'hFF); send_flag(); send_idle(12);
        // abort after 12 data bits
        send_flag();
        for (int i = 0; i < 12; i++) send_data_bit(1'($urandom_range(0, 1)));
        send_abort(); send_idle(10);
        // non-octet frame of 11 bits
        send_flag();
        for (int i = 0; i < 11; i++) send_data_bit(1'($urandom_range(0, 1)));
        send_flag(); send_idle(12);
        // reset after the first of three bytes has been delivered
        send_flag(); send_byte(8'h3C); send_byte(8'h81);
        step(1'b1, 1'b1, 1'b0);
        send_byte(8'h5A); send_flag(); send_idle(12);
        // back-to-back flags
        send_flag(); send_flag(); send_byte(8'h96); send_flag(); send_flag(); send_idle(12);
        // receiver disabled mid-frame, then a clean frame
        send_flag(); send_byte(8'hC3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        send_flag(); send_byte(8'h7E); send_flag(); send_idle(12);
        // randomized frames
        for (int f = 0; f < 60; f++) begin
            send_flag();
            if ($urandom_range(0, 3) == 0) send_flag();
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < $urandom_range(1, 7); i++) send_data_bit(1'($urandom_range(0, 1)));
            end
            kind = $urandom_range(0, 9);
            if (kind < 8) begin
                send_flag();
            end else if (kind == 8) begin
                send_abort();
            end else begin
                step(1'b1, 1'b1, 1'b0);
            end
            send_idle($urandom_range(0, 10));
        end
        send_idle(24);
        @(negedge Clk);
        #1;
        while (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL leftover_%s: never seen, required at edge %0d", exp_q[0].kind.name(), exp_q[0].edge_n);
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
